// File: rtl/xor_mem_write_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : xor_mem_write_scheduler
// Description : Round-robin write-port scheduler for an XOR-based multi-ported
//               memory. Each cycle it grants up to PORTS requesters and never
//               issues two writes to the same address in one cycle.
//               Optional post-reset zeroing sweep, compiled in when the macro
//               XOR_MEM_WRITE_SCHEDULER_INIT_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module xor_mem_write_scheduler #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 1024,
  parameter int PORTS = 2,
  parameter int REQS  = 4
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [REQS-1:0]                   req_valid,
  input  logic [REQS*$clog2(DEPTH)-1:0]     req_addr,
  input  logic [REQS*WIDTH-1:0]             req_data,
  output logic [REQS-1:0]                   req_ready,
  output logic [PORTS*$clog2(DEPTH)-1:0]    mem_addr,
  output logic [PORTS*WIDTH-1:0]            mem_d,
  output logic [PORTS-1:0]                  mem_en,
  output logic                              busy
);

  localparam int AW  = $clog2(DEPTH);
  localparam int RRW = $clog2(REQS);
`ifdef XOR_MEM_WRITE_SCHEDULER_INIT_EN
  // Wide enough to hold cnt + p past DEPTH without wrapping.
  localparam int CNTW = AW + 6;
`endif

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t                 r_state;
  state_t                 w_state_next;
  logic [RRW-1:0]         r_rr;
  logic [RRW-1:0]         w_rr_next;

  logic [PORTS-1:0]       r_mem_en;
  logic [PORTS*AW-1:0]    r_mem_addr;
  logic [PORTS*WIDTH-1:0] r_mem_d;
  logic [PORTS-1:0]       w_mem_en_next;
  logic [PORTS*AW-1:0]    w_mem_addr_next;
  logic [PORTS*WIDTH-1:0] w_mem_d_next;

  logic [REQS-1:0]        w_ready;
  logic [PORTS-1:0]       w_gnt_en;
  logic [PORTS*AW-1:0]    w_gnt_addr;
  logic [PORTS*WIDTH-1:0] w_gnt_data;
  logic                   w_gnt_any;
  logic [RRW-1:0]         w_gnt_last;

`ifdef XOR_MEM_WRITE_SCHEDULER_INIT_EN
  logic [CNTW-1:0]        r_cnt;
  logic [CNTW-1:0]        w_cnt_next;
  logic                   r_busy;
`endif

  // Round-robin scan: k-th grant lands on port k, same-address requesters are skipped.
  always_comb begin : arb
    int             n;
    int             idx;
    logic           hit;
    logic [AW-1:0]  a;
    w_ready    = '0;
    w_gnt_en   = '0;
    w_gnt_addr = '0;
    w_gnt_data = '0;
    w_gnt_any  = 1'b0;
    w_gnt_last = '0;
    n          = 0;
    idx        = 0;
    hit        = 1'b0;
    a          = '0;
    // rst gates readiness so no transfer is advertised while reset is held.
    if (r_state == ST_RUN && !rst) begin
      for (int j = 0; j < REQS; j++) begin
        idx = int'(r_rr) + j;
        if (idx >= REQS) idx = idx - REQS;
        a   = req_addr[idx*AW +: AW];
        hit = 1'b0;
        for (int k = 0; k < PORTS; k++) begin
          if (k < n && w_gnt_addr[k*AW +: AW] == a) hit = 1'b1;
        end
        if (req_valid[idx] && n < PORTS && !hit) begin
          w_ready[idx] = 1'b1;
          for (int k = 0; k < PORTS; k++) begin
            if (k == n) begin
              w_gnt_en[k]               = 1'b1;
              w_gnt_addr[k*AW +: AW]    = a;
              w_gnt_data[k*WIDTH +: WIDTH] = req_data[idx*WIDTH +: WIDTH];
            end
          end
          w_gnt_any  = 1'b1;
          w_gnt_last = idx[RRW-1:0];
          n          = n + 1;
        end
      end
    end
  end

  // Next-state, next pointer and next registered port values.
  always_comb begin : fsm
`ifdef XOR_MEM_WRITE_SCHEDULER_INIT_EN
    logic [CNTW-1:0] s;
    s          = '0;
    w_cnt_next = r_cnt;
`endif
    w_state_next    = r_state;
    w_rr_next       = r_rr;
    w_mem_en_next   = w_gnt_en;
    w_mem_addr_next = w_gnt_addr;
    w_mem_d_next    = w_gnt_data;
`ifdef XOR_MEM_WRITE_SCHEDULER_INIT_EN
    if (r_state == ST_INIT) begin
      w_cnt_next = r_cnt + CNTW'(PORTS);
      w_mem_d_next = '0;
      for (int p = 0; p < PORTS; p++) begin
        s = r_cnt + CNTW'(p);
        w_mem_en_next[p]          = (s < CNTW'(DEPTH));
        w_mem_addr_next[p*AW +: AW] = s[AW-1:0];
      end
      if (r_cnt + CNTW'(PORTS) >= CNTW'(DEPTH)) w_state_next = ST_RUN;
    end
`endif
    if (w_gnt_any) begin
      w_rr_next = (w_gnt_last == RRW'(REQS-1)) ? '0 : w_gnt_last + RRW'(1);
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
`ifdef XOR_MEM_WRITE_SCHEDULER_INIT_EN
      r_state <= ST_INIT;
`else
      r_state <= ST_RUN;
`endif
    end else begin
      r_state <= w_state_next;
    end
  end

  // Registered write ports, round-robin pointer and sweep bookkeeping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rr       <= '0;
      r_mem_en   <= '0;
      r_mem_addr <= '0;
      r_mem_d    <= '0;
`ifdef XOR_MEM_WRITE_SCHEDULER_INIT_EN
      r_cnt      <= '0;
      r_busy     <= 1'b1;
`endif
    end else begin
      r_rr       <= w_rr_next;
      r_mem_en   <= w_mem_en_next;
      r_mem_addr <= w_mem_addr_next;
      r_mem_d    <= w_mem_d_next;
`ifdef XOR_MEM_WRITE_SCHEDULER_INIT_EN
      r_cnt      <= w_cnt_next;
      // Drops on the edge that registers the first RUN-cycle grants.
      r_busy     <= (r_state == ST_INIT);
`endif
    end
  end

  assign req_ready = w_ready;
  assign mem_en    = r_mem_en;
  assign mem_addr  = r_mem_addr;
  assign mem_d     = r_mem_d;
`ifdef XOR_MEM_WRITE_SCHEDULER_INIT_EN
  assign busy      = r_busy;
`else
  assign busy      = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_xor_mem_write_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_xor_mem_write_scheduler
// Description : Self-checking bench: directed table, init/reset sequences and
//               randomized traffic against a queue-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_xor_mem_write_scheduler;

  localparam int WIDTH = 8;
  localparam int DEPTH = 16;
  localparam int PORTS = 2;
  localparam int REQS  = 4;
  localparam int AW    = 4;

  logic                   clk = 1'b0;
  logic                   rst = 1'b1;
  logic [REQS-1:0]        req_valid = '0;
  logic [REQS*AW-1:0]     req_addr  = '0;
  logic [REQS*WIDTH-1:0]  req_data  = '0;
  logic [REQS-1:0]        req_ready;
  logic [PORTS*AW-1:0]    mem_addr;
  logic [PORTS*WIDTH-1:0] mem_d;
  logic [PORTS-1:0]       mem_en;
  logic                   busy;

  int total = 0;
  int bad   = 0;
  int m_rr  = 0;

  always #5 clk = ~clk;

  xor_mem_write_scheduler #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .PORTS(PORTS), .REQS(REQS)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_addr(req_addr), .req_data(req_data),
    .req_ready(req_ready),
    .mem_addr(mem_addr), .mem_d(mem_d), .mem_en(mem_en), .busy(busy)
  );

  typedef struct {
    logic [3:0]  valid;
    logic [15:0] addr;
    logic [31:0] data;
    logic [3:0]  ready;
    logic [1:0]  en;
    logic [7:0]  maddr;
    logic [15:0] md;
  } vec_t;

  vec_t tbl [8];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h @%0t", nm, act, exp, $time);
    end
  endtask

  // Reference: scan from rr, grant valid requesters whose address is not yet
  // in this cycle's granted-address list, until PORTS grants are made.
  task automatic model_step(output logic [REQS-1:0] rdy, output logic [PORTS-1:0] en,
                            output logic [PORTS*AW-1:0] ma, output logic [PORTS*WIDTH-1:0] md,
                            output int nrr);
    logic [AW-1:0] q[$];
    int last;
    rdy = '0; en = '0; ma = '0; md = '0; last = -1;
    for (int j = 0; j < REQS; j++) begin
      int i;
      logic clash;
      logic [AW-1:0] a;
      i = (m_rr + j) % REQS;
      a = req_addr[i*AW +: AW];
      clash = 1'b0;
      foreach (q[k]) if (q[k] == a) clash = 1'b1;
      if (req_valid[i] && q.size() < PORTS && !clash) begin
        en[q.size()] = 1'b1;
        ma[q.size()*AW +: AW] = a;
        md[q.size()*WIDTH +: WIDTH] = req_data[i*WIDTH +: WIDTH];
        q.push_back(a);
        rdy[i] = 1'b1;
        last = i;
      end
    end
    nrr = (last >= 0) ? (last + 1) % REQS : m_rr;
  endtask

  // Pulse reset, let any sweep finish, and leave the bench at posedge+1.
  task automatic reset_seq();
    int n;
    req_valid = '0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
`ifdef XOR_MEM_WRITE_SCHEDULER_INIT_EN
    n = 0;
    while (busy !== 1'b0 && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    if (busy !== 1'b0) begin
      total++; bad++;
      $display("FAIL sweep_timeout actual busy=%b required busy=0 within 40 cycles", busy);
    end
`else
    n = 0;
`endif
    m_rr = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=time limit reached required=bench completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [REQS-1:0]        e_rdy;
    logic [PORTS-1:0]       e_en;
    logic [PORTS*AW-1:0]    e_ma;
    logic [PORTS*WIDTH-1:0] e_md;
    int                     nrr;
    logic                   pend [REQS];
    logic [AW-1:0]          pa   [REQS];
    logic [WIDTH-1:0]       pd   [REQS];
    int                     n;

    tbl[0] = '{4'b1111, 16'h4321, 32'h40302010, 4'b0011, 2'b11, 8'h21, 16'h2010};
    tbl[1] = '{4'b1111, 16'h4321, 32'h40302010, 4'b1100, 2'b11, 8'h43, 16'h4030};
    tbl[2] = '{4'b1111, 16'h4321, 32'h40302010, 4'b0011, 2'b11, 8'h21, 16'h2010};
    tbl[3] = '{4'b1100, 16'h4321, 32'h40302010, 4'b1100, 2'b11, 8'h43, 16'h4030};
    tbl[4] = '{4'b0111, 16'h0755, 32'h00332211, 4'b0101, 2'b11, 8'h75, 16'h3311};
    tbl[5] = '{4'b0010, 16'h0755, 32'h00332211, 4'b0010, 2'b01, 8'h05, 16'h0022};
    tbl[6] = '{4'b1000, 16'h9000, 32'hA5000000, 4'b1000, 2'b01, 8'h09, 16'h00A5};
    tbl[7] = '{4'b0000, 16'h0000, 32'h00000000, 4'b0000, 2'b00, 8'h00, 16'h0000};

    // Reset values, checked while rst is held and before any clock edge.
    req_valid = 4'b0001; req_addr = 16'h0003; req_data = 32'h0000003C;
    #2;
    chk("rst_en",    64'(mem_en),    64'd0);
    chk("rst_addr",  64'(mem_addr),  64'd0);
    chk("rst_d",     64'(mem_d),     64'd0);
    chk("rst_ready", 64'(req_ready), 64'd0);
`ifdef XOR_MEM_WRITE_SCHEDULER_INIT_EN
    chk("rst_busy",  64'(busy),      64'd1);
`else
    chk("rst_busy",  64'(busy),      64'd0);
`endif

    @(posedge clk); #1;
    rst = 1'b0;
`ifdef XOR_MEM_WRITE_SCHEDULER_INIT_EN
    // Sweep: 8 cycles of zero writes to (0,1)..(14,15); req0 held waiting.
    #4;
    chk("init_ready0", 64'(req_ready), 64'd0);
    chk("init_busy0",  64'(busy),      64'd1);
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      chk($sformatf("sweep%0d_en", c),   64'(mem_en),   64'(2'b11));
      chk($sformatf("sweep%0d_addr", c), 64'(mem_addr), 64'({AW'(2*c+1), AW'(2*c)}));
      chk($sformatf("sweep%0d_d", c),    64'(mem_d),    64'd0);
      chk($sformatf("sweep%0d_busy", c), 64'(busy),     64'd1);
      #3;
      chk($sformatf("sweep%0d_ready", c), 64'(req_ready), (c == 7) ? 64'd1 : 64'd0);
    end
    @(posedge clk); #1;
    chk("first_run_busy", 64'(busy),     64'd0);
    chk("first_run_en",   64'(mem_en),   64'(2'b01));
    chk("first_run_addr", 64'(mem_addr), 64'h03);
    chk("first_run_d",    64'(mem_d),    64'h003C);
`else
    #4;
    chk("run_ready0", 64'(req_ready), 64'd1);
    chk("run_busy0",  64'(busy),      64'd0);
    @(posedge clk); #1;
    chk("first_run_en",   64'(mem_en),   64'(2'b01));
    chk("first_run_addr", 64'(mem_addr), 64'h03);
    chk("first_run_d",    64'(mem_d),    64'h003C);
`endif

    // Directed table starting from rr=0.
    reset_seq();
    for (int r = 0; r < 8; r++) begin
      req_valid = tbl[r].valid;
      req_addr  = tbl[r].addr;
      req_data  = tbl[r].data;
      #4;
      chk($sformatf("tbl%0d_ready", r), 64'(req_ready), 64'(tbl[r].ready));
      @(posedge clk); #1;
      chk($sformatf("tbl%0d_en", r),   64'(mem_en),   64'(tbl[r].en));
      chk($sformatf("tbl%0d_addr", r), 64'(mem_addr), 64'(tbl[r].maddr));
      chk($sformatf("tbl%0d_d", r),    64'(mem_d),    64'(tbl[r].md));
    end

    // Randomized traffic; requesters hold addr/data until accepted.
    reset_seq();
    for (int i = 0; i < REQS; i++) begin
      pend[i] = 1'b0; pa[i] = '0; pd[i] = '0;
    end
    for (int cyc = 0; cyc < 400; cyc++) begin
      for (int i = 0; i < REQS; i++) begin
        if (!pend[i] && $urandom_range(0, 2) != 0) begin
          pend[i] = 1'b1;
          pa[i] = ($urandom_range(0, 3) == 0) ? AW'($urandom_range(0, DEPTH-1))
                                              : AW'($urandom_range(0, 3));
          pd[i] = WIDTH'($urandom);
        end
        req_valid[i] = pend[i];
        req_addr[i*AW +: AW] = pa[i];
        req_data[i*WIDTH +: WIDTH] = pd[i];
      end
      #4;
      model_step(e_rdy, e_en, e_ma, e_md, nrr);
      chk($sformatf("rnd%0d_ready", cyc), 64'(req_ready), 64'(e_rdy));
      @(posedge clk); #1;
      chk($sformatf("rnd%0d_en", cyc),   64'(mem_en),   64'(e_en));
      chk($sformatf("rnd%0d_addr", cyc), 64'(mem_addr), 64'(e_ma));
      chk($sformatf("rnd%0d_d", cyc),    64'(mem_d),    64'(e_md));
      m_rr = nrr;
      for (int i = 0; i < REQS; i++) if (e_rdy[i]) pend[i] = 1'b0;
    end

    // Asynchronous reset while both ports are writing.
    reset_seq();
    req_valid = 4'b1111; req_addr = 16'h4321; req_data = 32'h40302010;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (mem_en !== 2'b11 && n < 5);
    chk("midrst_pre_en", 64'(mem_en), 64'(2'b11));
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_en",    64'(mem_en),    64'd0);
    chk("midrst_addr",  64'(mem_addr),  64'd0);
    chk("midrst_d",     64'(mem_d),     64'd0);
    chk("midrst_ready", 64'(req_ready), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
`ifdef XOR_MEM_WRITE_SCHEDULER_INIT_EN
    @(posedge clk); #1;
    chk("midrst_sweep_en",   64'(mem_en),   64'(2'b11));
    chk("midrst_sweep_addr", 64'(mem_addr), 64'h10);
    chk("midrst_sweep_d",    64'(mem_d),    64'd0);
    chk("midrst_sweep_busy", 64'(busy),     64'd1);
`else
    #4;
    chk("midrst_resume_ready", 64'(req_ready), 64'(4'b0011));
    @(posedge clk); #1;
    chk("midrst_resume_addr", 64'(mem_addr), 64'h21);
    chk("midrst_resume_d",    64'(mem_d),    64'h2010);
`endif
    req_valid = '0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/xor_mem_write_scheduler.md
# xor_mem_write_scheduler

Write-port scheduler for the XOR-based multi-ported distributed memory. It arbitrates REQS independent write requesters onto the memory's PORTS write ports each cycle using round-robin priority. It never issues two writes to the same address in one cycle, because the XOR memory's result is undefined on a same-cycle collision. An optional post-reset sweep zeroes every memory word so all XOR banks start consistent.

## Interface
Parameters:
- WIDTH, 32, data word width
- DEPTH, 1024, memory words; AW = $clog2(DEPTH)
- PORTS, 2, memory write ports (1..REQS)
- REQS, 4, number of requesters (2..16)

Ports:
- clk  in  1  single clock; all logic on posedge
- rst  in  1  reset, asynchronous, active-high
- req_valid  in  REQS  request valid, bit i = requester i
- req_addr  in  REQS*AW  packed; slice i = [(i+1)*AW-1 -: AW]
- req_data  in  REQS*WIDTH  packed, same slicing with WIDTH
- req_ready  out  REQS  combinational grant; transfer when valid & ready
- mem_addr  out  PORTS*AW  registered address per port, packed
- mem_d  out  PORTS*WIDTH  registered write data per port, packed
- mem_en  out  PORTS  registered write enable per port
- busy  out  1  registered; 1 while the init sweep runs

## Operation
- FSM states: INIT (only with the macro) and RUN. Reset enters INIT if the macro is defined, otherwise RUN.
- INIT:
  - Counter cnt starts at 0. Port p drives addr cnt+p, d=0, en=1 when cnt+p < DEPTH, otherwise en=0.
  - cnt increments by PORTS each cycle.
  - The sweep takes ceil(DEPTH/PORTS) cycles, then the FSM moves to RUN.
  - All req_ready are 0 throughout INIT.
- RUN arbitration (combinational, each cycle):
  - Scan requesters in order rr, rr+1, ... modulo REQS.
  - Grant requester i if req_valid[i], fewer than PORTS grants are already made, and req_addr[i] differs from every address already granted this cycle.
  - A conflicting requester is skipped, not stalled. Later requesters in the scan can still be granted.
  - The k-th grant in scan order maps to port k. Unused ports get en=0, addr=0, d=0.
- Round-robin pointer rr (reset 0):
  - After a cycle with at least one grant, rr = (last granted index + 1) mod REQS.
  - With no grant, rr is unchanged.
- Requesters must hold addr and data stable while valid and not ready. The block does not check this.
- Reset values: mem_en=0, mem_addr=0, mem_d=0, req_ready=0, rr=0, cnt=0. busy=1 with the macro, 0 without it.
- Reset mid-operation: all outputs clear immediately and asynchronously. Any in-flight write is dropped. The init sweep restarts from address 0.

## Timing
- Grant at cycle t, meaning req_valid[i] & req_ready[i] at edge t. The write appears on mem_* in the cycle after edge t, so latency is 1.
- Throughput: up to PORTS writes per cycle when addresses are distinct.
- busy falls on the same edge where the first RUN-cycle grants are registered. req_ready can assert combinationally in the first RUN cycle.
- Same-address requests from different requesters are serialized across cycles in round-robin order. No merging or reordering happens within a requester.
- Starvation-free: any requester held valid is granted within REQS cycles.

## Configuration
- XOR_MEM_WRITE_SCHEDULER_INIT_EN:
  - Defined: the INIT state and counter are compiled in. busy is 1 from reset until the sweep completes.
  - Undefined: no INIT state. Reset goes straight to RUN, busy is tied to 0, and the memory contents after reset are unspecified.

## Test plan
- INIT sweep (macro on, DEPTH=16, PORTS=2) -> busy=1 for 8 cycles; mem_addr pairs (0,1),(2,3)…(14,15); mem_d=0; en=11 each cycle; then busy=0 and req_ready becomes live.
- RUN, REQS=4, all valid, addrs 1,2,3,4, rr=0 -> cycle 1 grants req0/req1 on ports 0/1 (addrs 1,2 visible next cycle); cycle 2 grants req2/req3; cycle 3 grants req0/req1.
- Collision: req0 addr 5, req1 addr 5, req2 addr 7, rr=0 -> grants req0 (port 0) and req2 (port 1); req1 deferred; rr=3. Next cycle, with req0/req2 deasserted, req1 is granted on port 0 with addr 5.
- Single requester: only req3 valid, addr 9, data 0xA5 -> next cycle port 0 en=1, addr=9, d=0xA5; port 1 en=0, addr=0, d=0; rr=0.
- Requests during INIT: req0 valid from reset -> req_ready[0]=0 until busy falls; req0 granted in the first RUN cycle.
- Reset mid-operation: assert rst while mem_en=11 -> mem_en, mem_addr, mem_d and req_ready go to 0 without a clock edge. After release, the sweep restarts from address 0 (macro on), or arbitration resumes with rr=0 (macro off).
